// File: rtl/mypackage.sv
// Shared definitions for the voice allocator: default sizes, note type and FSM states.
package mypackage;
  localparam int NVOICES   = 4;
  localparam int NOTE_BITS = 7;

  typedef logic [NOTE_BITS-1:0] note_t;

  typedef enum logic {
    IDLE   = 1'b0,
    RETRIG = 1'b1
  } alloc_state_t;
endpackage

// File: rtl/voice_allocator_pick.sv
// Combinational voice selection: retrigger same note, else free, else releasing, else oldest.
module voice_pick #(
  parameter int NVOICES   = 4,
  parameter int NOTE_BITS = 7,
  parameter int AW        = $clog2(NVOICES)
) (
  input  logic [NVOICES-1:0]                gates,
  input  logic [NVOICES-1:0]                actives,
  input  logic [NVOICES-1:0][NOTE_BITS-1:0] notes,
  input  logic [NVOICES-1:0][AW-1:0]        ages,
  input  logic [NOTE_BITS-1:0]              req_note,
  output logic [AW-1:0]                     sel,
  output logic                              retrig
);
  logic          hit_a, hit_b, hit_c;
  logic [AW-1:0] idx_a, idx_b, idx_c, idx_old;

  always_comb begin
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    hit_c   = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    idx_c   = '0;
    idx_old = '0;
    // Ascending scan, first hit kept, so the lowest index wins each class
    for (int unsigned i = 0; i < NVOICES; i++) begin
      if (!hit_a && gates[i] && notes[i] == req_note) begin
        hit_a = 1'b1;
        idx_a = AW'(i);
      end
      if (!hit_b && !gates[i] && !actives[i]) begin
        hit_b = 1'b1;
        idx_b = AW'(i);
      end
      if (!hit_c && !gates[i]) begin
        hit_c = 1'b1;
        idx_c = AW'(i);
      end
      if (ages[i] == AW'(NVOICES - 1))
        idx_old = AW'(i);
    end
  end

  always_comb begin
    if (hit_a)      sel = idx_a;
    else if (hit_b) sel = idx_b;
    else if (hit_c) sel = idx_c;
    else            sel = idx_old;
    retrig = hit_a || (!hit_b && !hit_c);
  end
endmodule

// File: rtl/voice_allocator.sv
// Note-on/note-off allocator for NVOICES NCO+ADSR slots with LRU stealing and gate retrigger.
module voice_allocator #(
  parameter int NVOICES   = mypackage::NVOICES,
  parameter int NOTE_BITS = mypackage::NOTE_BITS
) (
  input  logic                              CLOCK_50,
  input  logic                              reset,
  input  logic                              on_valid,
  output logic                              on_ready,
  input  logic [NOTE_BITS-1:0]              on_note,
  input  logic                              off_valid,
  input  logic [NOTE_BITS-1:0]              off_note,
  input  logic [NVOICES-1:0]                voice_active,
  output logic [NVOICES-1:0]                voice_gate,
  output logic [NVOICES-1:0][NOTE_BITS-1:0] voice_note
);
  localparam int AW = $clog2(NVOICES);

  mypackage::alloc_state_t          state_q, state_d;
  logic [NVOICES-1:0]               gate_post, gate_d;
  logic [NVOICES-1:0][NOTE_BITS-1:0] note_d;
  logic [NVOICES-1:0][AW-1:0]       age_q, age_d;
  logic [AW-1:0]                    sel, pend_idx_q, pend_idx_d;
  logic [NOTE_BITS-1:0]             pend_note_q, pend_note_d;
  logic                             retrig, cnt_q, cnt_d;

  assign on_ready = (state_q == mypackage::IDLE);

  // Note-off is applied before selection so a same-cycle note-on sees the released gates
  always_comb begin
    for (int unsigned i = 0; i < NVOICES; i++)
      gate_post[i] = voice_gate[i] && !(off_valid && voice_note[i] == off_note);
  end

  voice_pick #(
    .NVOICES  (NVOICES),
    .NOTE_BITS(NOTE_BITS),
    .AW       (AW)
  ) u_pick (
    .gates   (gate_post),
    .actives (voice_active),
    .notes   (voice_note),
    .ages    (age_q),
    .req_note(on_note),
    .sel     (sel),
    .retrig  (retrig)
  );

  always_comb begin
    state_d     = state_q;
    gate_d      = gate_post;
    note_d      = voice_note;
    age_d       = age_q;
    pend_idx_d  = pend_idx_q;
    pend_note_d = pend_note_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      mypackage::IDLE: begin
        if (on_valid) begin
          for (int unsigned i = 0; i < NVOICES; i++) begin
            if (AW'(i) == sel)               age_d[i] = '0;
            else if (age_q[i] < age_q[sel])  age_d[i] = age_q[i] + 1'b1;
          end
          if (retrig) begin
            gate_d[sel] = 1'b0;
            pend_idx_d  = sel;
            pend_note_d = on_note;
            cnt_d       = 1'b0;
            state_d     = mypackage::RETRIG;
          end else begin
            gate_d[sel] = 1'b1;
            note_d[sel] = on_note;
          end
        end
      end
      mypackage::RETRIG: begin
        if (off_valid && off_note == pend_note_q) begin
          state_d = mypackage::IDLE;
        end else if (cnt_q) begin
          gate_d[pend_idx_q] = 1'b1;
          note_d[pend_idx_q] = pend_note_q;
          state_d            = mypackage::IDLE;
        end else begin
          cnt_d = 1'b1;
        end
      end
      default: state_d = mypackage::IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= mypackage::IDLE;
      voice_gate  <= '0;
      voice_note  <= '0;
      pend_idx_q  <= '0;
      pend_note_q <= '0;
      cnt_q       <= 1'b0;
      for (int unsigned i = 0; i < NVOICES; i++)
        age_q[i] <= AW'(i);
    end else begin
      state_q     <= state_d;
      voice_gate  <= gate_d;
      voice_note  <= note_d;
      age_q       <= age_d;
      pend_idx_q  <= pend_idx_d;
      pend_note_q <= pend_note_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule
